// File: rtl/udm_uart_pkg.sv
// udm_uart_pkg: shared receiver state type and framing constants for the UDM UART blocks.
package udm_uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;
  localparam int MIN_DIV = 4;
  localparam int DATA_BITS = 8;
endpackage

// File: rtl/udm_sync.sv
// udm_sync: N-flop synchroniser for asynchronous inputs; resets to 1 so an idle-high line looks idle.
module udm_sync #(
  parameter int N = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic [N-1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[N-2:0], d_i};
  always_ff @(posedge clk_i)
    if (rst_i) sync_q <= '1;
    else sync_q <= sync_d;
  assign q_o = sync_q[N-1];
endmodule

// File: rtl/udm_uart_rx.sv
// udm_uart_rx: 8N1 UART receiver with runtime baud divider and one-entry output buffer.
// Defining UDM_UART_RX_PARITY_EN adds a parity bit (parity_odd_i selects odd) and parity_err_o.
module udm_uart_rx
  import udm_uart_pkg::*;
#(
  parameter int DIV_WIDTH   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  input  logic [DIV_WIDTH-1:0] clk_div_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
`ifdef UDM_UART_RX_PARITY_EN
  input  logic                 parity_odd_i,
  output logic                 parity_err_o,
`endif
  output logic                 busy_o
);
  localparam logic [DIV_WIDTH-1:0] MIN_D = DIV_WIDTH'(MIN_DIV);
  rx_state_t state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d, cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic rxs, rxs_prev_q, rxs_prev_d, valid_q, valid_d;
  logic frame_err_q, frame_err_d, overrun_q, overrun_d, bad_q, bad_d;
  logic fall, half, full, done, load;

  udm_sync #(.N(SYNC_STAGES)) u_sync (.clk_i(clk_i), .rst_i(rst_i), .d_i(rx_i), .q_o(rxs));

  assign fall = rxs_prev_q & ~rxs;
  assign half = cnt_q == (div_q >> 1);
  assign full = cnt_q == div_q - DIV_WIDTH'(1);

  // The fall cycle itself counts as cnt=0, so START samples exactly div/2 cycles after the edge.
  always_comb begin
    state_d = state_q;
    div_d = div_q;
    cnt_d = cnt_q + DIV_WIDTH'(1);
    idx_d = idx_q;
    shift_d = shift_q;
    bad_d = bad_q;
    frame_err_d = 1'b0;
    done = 1'b0;
    rxs_prev_d = rxs;
    unique case (state_q)
      IDLE: if (fall) begin
        state_d = START;
        div_d = clk_div_i < MIN_D ? MIN_D : clk_div_i;
        cnt_d = DIV_WIDTH'(1);
        bad_d = 1'b0;
      end
      START: if (half) begin
        state_d = rxs ? IDLE : DATA;
        cnt_d = '0;
        idx_d = '0;
      end
      DATA: if (full) begin
        shift_d = {rxs, shift_q[DATA_BITS-1:1]};
        cnt_d = '0;
        idx_d = idx_q + 3'd1;
`ifdef UDM_UART_RX_PARITY_EN
        if (idx_q == 3'(DATA_BITS - 1)) state_d = PARITY;
`else
        if (idx_q == 3'(DATA_BITS - 1)) state_d = STOP;
`endif
      end
`ifdef UDM_UART_RX_PARITY_EN
      PARITY: if (full) begin
        cnt_d = '0;
        bad_d = rxs ^ (^shift_q) ^ parity_odd_i;
        state_d = STOP;
      end
`endif
      STOP: if (full) begin
        state_d = rxs ? IDLE : BREAK;
        frame_err_d = ~rxs;
        done = rxs & ~bad_q;
      end
      BREAK: if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    load = done & (~valid_q | ready_i);
    valid_d = load | (valid_q & ~ready_i);
    data_d = load ? shift_q : data_q;
    overrun_d = done & valid_q & ~ready_i;
  end

  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q <= IDLE;
      rxs_prev_q <= 1'b1;
      div_q <= MIN_D;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q <= 1'b0;
      bad_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rxs_prev_q <= rxs_prev_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      data_q <= data_d;
      valid_q <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q <= overrun_d;
      bad_q <= bad_d;
    end

  assign data_o = data_q;
  assign valid_o = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o = overrun_q;
  assign busy_o = state_q != IDLE;
`ifdef UDM_UART_RX_PARITY_EN
  // bad_q is set on the PARITY sample, so the first STOP cycle is the one-cycle error pulse.
  assign parity_err_o = bad_q && state_q == STOP && cnt_q == '0;
`endif
endmodule

// File: tb/tb_udm_uart_rx.sv
// tb_udm_uart_rx: randomized self-checking bench for udm_uart_rx against a frame-level timing model.
module tb_udm_uart_rx;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic rx_i = 1'b1;
  logic [31:0] clk_div_i = 32'd16;
  logic [7:0] data_o;
  logic valid_o, ready_i, frame_err_o, overrun_o, busy_o;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = 0, rise_cnt = 0, fe_cnt = 0, ov_cnt = 0, busy_cnt = 0;
  logic vprev = 1'b0;
  logic [7:0] got[$];

  udm_uart_rx #(.DIV_WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx_i), .clk_div_i(clk_div_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .frame_err_o(frame_err_o), .overrun_o(overrun_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (valid_o && ready_i) got.push_back(data_o);
    if (valid_o && !vprev) begin
      rise_cyc = cyc;
      rise_cnt++;
    end
    vprev = valid_o;
    if (frame_err_o) fe_cnt++;
    if (overrun_o) ov_cnt++;
    if (busy_o) busy_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  function automatic int eff_div(input int div);
    return div < 4 ? 4 : div;
  endfunction

  // Valid rises one cycle after the stop-bit sample, which lies mid-stop-bit after the 2-flop sync delay.
  function automatic int exp_rise(input int k, input int div);
    int e;
    e = eff_div(div);
    return k + 2 + e / 2 + 9 * e + 1;
  endfunction

  task automatic drive_frame(input logic [7:0] b, input int div, input bit stop, input bit scramble, output int k);
    logic [9:0] f;
    int len;
    f = {stop, b, 1'b0};
    len = eff_div(div);
    clk_div_i = 32'(div);
    k = cyc;
    for (int i = 0; i < 10; i++) begin
      rx_i = f[i];
      if (i == 1 && scramble) clk_div_i = $urandom_range(4, 200);
      tick(len);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    ready_i = 1'b0;
    tick(3);
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data got %h expected 00", data_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", valid_o); end
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b expected 0", frame_err_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b expected 0", overrun_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy_o); end
    rst_i = 1'b0;
    tick(5);
  endtask

  task automatic test_single();
    int k, div;
    logic [7:0] b;
    for (int n = 0; n < 6; n++) begin
      div = n == 0 ? 16 : n == 1 ? 2 : int'($urandom_range(4, 40));
      b = n == 0 ? 8'h55 : 8'($urandom);
      rise_cnt = 0;
      fe_cnt = 0;
      ov_cnt = 0;
      drive_frame(b, div, 1'b1, n >= 2, k);
      tick(eff_div(div) + 4);
      checks++; if (rise_cnt !== 1) begin errors++; $display("FAIL single_rise_count n=%0d got %0d expected 1", n, rise_cnt); end
      checks++; if (rise_cyc !== exp_rise(k, div)) begin errors++; $display("FAIL single_latency n=%0d got %0d expected %0d", n, rise_cyc, exp_rise(k, div)); end
      checks++; if (data_o !== b) begin errors++; $display("FAIL single_data n=%0d got %h expected %h", n, data_o, b); end
      checks++; if (fe_cnt + ov_cnt !== 0) begin errors++; $display("FAIL single_pulses n=%0d got %0d expected 0", n, fe_cnt + ov_cnt); end
      ready_i = 1'b1;
      tick(1);
      ready_i = 1'b0;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL single_consume n=%0d got %b expected 0", n, valid_o); end
      checks++; if (data_o !== b) begin errors++; $display("FAIL single_hold n=%0d got %h expected %h", n, data_o, b); end
      tick(3);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    ready_i = 1'b1;
    got.delete();
    ov_cnt = 0;
    drive_frame(8'hA5, 868, 1'b1, 1'b0, k);
    drive_frame(8'h3C, 868, 1'b1, 1'b0, k);
    tick(900);
    checks++; if (got.size() !== 2) begin errors++; $display("FAIL b2b_count got %0d expected 2", got.size()); end
    else begin
      checks++; if (got[0] !== 8'hA5) begin errors++; $display("FAIL b2b_first got %h expected a5", got[0]); end
      checks++; if (got[1] !== 8'h3C) begin errors++; $display("FAIL b2b_second got %h expected 3c", got[1]); end
    end
    got.delete();
    for (int n = 0; n < 5; n++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      drive_frame(b, int'($urandom_range(4, 24)), 1'b1, 1'b0, k);
    end
    tick(40);
    checks++; if (got.size() !== 5) begin errors++; $display("FAIL b2b_rand_count got %0d expected 5", got.size()); end
    else for (int n = 0; n < 5; n++) begin
      checks++; if (got[n] !== exp_q[n]) begin errors++; $display("FAIL b2b_rand_data n=%0d got %h expected %h", n, got[n], exp_q[n]); end
    end
    checks++; if (ov_cnt !== 0) begin errors++; $display("FAIL b2b_overrun got %0d expected 0", ov_cnt); end
    ready_i = 1'b0;
  endtask

  task automatic test_glitch();
    clk_div_i = 32'd16;
    rise_cnt = 0;
    fe_cnt = 0;
    busy_cnt = 0;
    rx_i = 1'b0;
    tick(5);
    rx_i = 1'b1;
    tick(40);
    checks++; if (busy_cnt !== 8) begin errors++; $display("FAIL glitch_busy got %0d expected 8", busy_cnt); end
    checks++; if (rise_cnt !== 0) begin errors++; $display("FAIL glitch_valid got %0d expected 0", rise_cnt); end
    checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL glitch_frame_err got %0d expected 0", fe_cnt); end
  endtask

  task automatic test_break();
    int k;
    rise_cnt = 0;
    fe_cnt = 0;
    drive_frame(8'hFF, 16, 1'b0, 1'b0, k);
    tick(100);
    rx_i = 1'b1;
    tick(20);
    checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL break_frame_err got %0d expected 1", fe_cnt); end
    checks++; if (rise_cnt !== 0) begin errors++; $display("FAIL break_valid got %0d expected 0", rise_cnt); end
    drive_frame(8'h12, 16, 1'b1, 1'b0, k);
    tick(20);
    checks++; if (valid_o !== 1'b1 || data_o !== 8'h12) begin errors++; $display("FAIL break_recover got %b/%h expected 1/12", valid_o, data_o); end
    checks++; if (rise_cyc !== exp_rise(k, 16)) begin errors++; $display("FAIL break_latency got %0d expected %0d", rise_cyc, exp_rise(k, 16)); end
    ready_i = 1'b1;
    tick(1);
    ready_i = 1'b0;
  endtask

  task automatic test_overrun();
    int k;
    ov_cnt = 0;
    rise_cnt = 0;
    drive_frame(8'h11, 16, 1'b1, 1'b0, k);
    drive_frame(8'h22, 16, 1'b1, 1'b0, k);
    tick(20);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL overrun_valid got %b expected 1", valid_o); end
    checks++; if (data_o !== 8'h11) begin errors++; $display("FAIL overrun_data got %h expected 11", data_o); end
    checks++; if (ov_cnt !== 1) begin errors++; $display("FAIL overrun_pulse got %0d expected 1", ov_cnt); end
    checks++; if (rise_cnt !== 1) begin errors++; $display("FAIL overrun_rise got %0d expected 1", rise_cnt); end
  endtask

  task automatic test_reset_mid();
    int k;
    logic [7:0] b;
    b = 8'h77;
    clk_div_i = 32'd16;
    rx_i = 1'b0;
    tick(16);
    for (int i = 0; i < 3; i++) begin
      rx_i = b[i];
      tick(16);
    end
    fe_cnt = 0;
    ov_cnt = 0;
    rst_i = 1'b1;
    tick(1);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b expected 0", busy_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b expected 0", valid_o); end
    rst_i = 1'b0;
    rx_i = 1'b1;
    tick(20);
    checks++; if (fe_cnt + ov_cnt !== 0) begin errors++; $display("FAIL rstmid_pulses got %0d expected 0", fe_cnt + ov_cnt); end
    drive_frame(8'h81, 16, 1'b1, 1'b0, k);
    tick(20);
    checks++; if (valid_o !== 1'b1 || data_o !== 8'h81) begin errors++; $display("FAIL rstmid_next got %b/%h expected 1/81", valid_o, data_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_overrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
